// File: rtl/sm_eth_pkg.sv
// ---------------------------------------------------------------------------
// sm_eth_pkg : state encoding and default 20 MHz timing for the Ethernet TX
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sm_eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NLP    = 3'd1,
    S_DATA   = 3'd2,
    S_TPIDLE = 3'd3,
    S_IPG    = 3'd4
  } state_e;

  localparam int NLP_PERIOD_20M = 320000;
  localparam int NLP_WIDTH_20M  = 2;
  localparam int TPIDLE_20M     = 6;
  localparam int IPG_20M        = 192;

endpackage

`default_nettype wire

// File: rtl/sm_eth_tx_mem.sv
// ---------------------------------------------------------------------------
// sm_eth_tx_mem : byte frame buffer, synchronous write, two async read ports
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sm_eth_tx_mem #(
  parameter int MEM_DEPTH = 128,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

`default_nettype wire

// File: rtl/sm_eth_tx.sv
// ---------------------------------------------------------------------------
// sm_eth_tx : 10BASE-T transmit engine (Manchester data, TP_IDLE, IPG, NLP)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sm_eth_tx
  import sm_eth_pkg::*;
#(
  parameter int MEM_DEPTH     = 128,
  parameter int NLP_PERIOD    = NLP_PERIOD_20M,
  parameter int NLP_WIDTH     = NLP_WIDTH_20M,
  parameter int TPIDLE_CYCLES = TPIDLE_20M,
  parameter int IPG_CYCLES    = IPG_20M,
  parameter int AW            = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          txp,
  output logic          txn,
  output logic          tx_active
);

  localparam int NW   = $clog2(NLP_PERIOD);
  localparam int TMAX = (IPG_CYCLES > TPIDLE_CYCLES)
                      ? ((IPG_CYCLES > NLP_WIDTH) ? IPG_CYCLES : NLP_WIDTH)
                      : ((TPIDLE_CYCLES > NLP_WIDTH) ? TPIDLE_CYCLES : NLP_WIDTH);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [NW-1:0] c_nlp_last    = NW'(NLP_PERIOD - 1);
  localparam logic [TW-1:0] c_nlpw_last   = TW'(NLP_WIDTH - 1);
  localparam logic [TW-1:0] c_tpidle_last = TW'(TPIDLE_CYCLES - 1);
  localparam logic [TW-1:0] c_ipg_last    = TW'(IPG_CYCLES - 1);
  localparam logic [AW:0]   c_depth       = (AW+1)'(MEM_DEPTH);

  state_e        state_q, state_d;
  logic [NW-1:0] nlp_cnt_q, nlp_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pend_q, pend_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic          phase_q, phase_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          txp_q, txp_d, txn_q, txn_d, tx_active_q, tx_active_d;

  logic          launch;
  logic          w_we, w_start_ok, w_last_bit;
  logic [AW:0]   w_len_clamped, w_byte_next;
  logic [2:0]    w_bit_next;
  logic [AW-1:0] w_tx_addr;
  logic [7:0]    w_tx_byte;

  // Buffer is frozen while a frame is on the wire so the sent bytes stay consistent.
  assign w_we          = wr_en && (state_q != S_DATA) && (state_q != S_TPIDLE);
  assign w_start_ok    = start && (len != '0);
  assign w_len_clamped = (len > c_depth) ? c_depth : len;
  assign w_byte_next   = byte_q + (AW+1)'(1);
  assign w_bit_next    = bit_q + 3'd1;
  assign w_last_bit    = (bit_q == 3'd7) && (w_byte_next == len_q);
  assign w_tx_addr     = (state_q == S_DATA) ? w_byte_next[AW-1:0] : '0;

  sm_eth_tx_mem #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we      (w_we),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (rd_addr),
    .rdata_a (rd_data),
    .raddr_b (w_tx_addr),
    .rdata_b (w_tx_byte)
  );

  always_comb begin
    state_d     = state_q;
    nlp_cnt_d   = '0;
    tmr_d       = tmr_q;
    pend_d      = pend_q;
    len_d       = len_q;
    byte_d      = byte_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    shreg_d     = shreg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    txp_d       = txp_q;
    txn_d       = txn_q;
    tx_active_d = tx_active_q;
    launch      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_start_ok) begin
          len_d  = w_len_clamped;
          launch = 1'b1;
        end else if (nlp_cnt_q == c_nlp_last) begin
          state_d = S_NLP;
          tmr_d   = '0;
          txp_d   = 1'b1;
          txn_d   = 1'b0;
        end else begin
          nlp_cnt_d = nlp_cnt_q + NW'(1);
        end
      end
      S_NLP: begin
        if (w_start_ok && !pend_q) begin
          pend_d = 1'b1;
          len_d  = w_len_clamped;
          busy_d = 1'b1;
        end
        if (tmr_q == c_nlpw_last) begin
          if (pend_q || w_start_ok) begin
            launch = 1'b1;
          end else begin
            state_d = S_IDLE;
            txp_d   = 1'b0;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          txp_d   = shreg_q[bit_q];
          txn_d   = ~shreg_q[bit_q];
        end else if (w_last_bit) begin
          state_d = S_TPIDLE;
          tmr_d   = '0;
          txp_d   = 1'b1;
          txn_d   = 1'b0;
        end else begin
          phase_d = 1'b0;
          if (bit_q == 3'd7) begin
            byte_d  = w_byte_next;
            bit_d   = 3'd0;
            shreg_d = w_tx_byte;
            txp_d   = ~w_tx_byte[0];
            txn_d   = w_tx_byte[0];
          end else begin
            bit_d = w_bit_next;
            txp_d = ~shreg_q[w_bit_next];
            txn_d = shreg_q[w_bit_next];
          end
        end
      end
      S_TPIDLE: begin
        if (tmr_q == c_tpidle_last) begin
          state_d     = S_IPG;
          tmr_d       = '0;
          done_d      = 1'b1;
          txp_d       = 1'b0;
          txn_d       = 1'b0;
          tx_active_d = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_IPG: begin
        if (tmr_q == c_ipg_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outside DATA the tx read port points at address 0, so the first byte is ready.
    if (launch) begin
      state_d     = S_DATA;
      pend_d      = 1'b0;
      busy_d      = 1'b1;
      tx_active_d = 1'b1;
      byte_d      = '0;
      bit_d       = 3'd0;
      phase_d     = 1'b0;
      shreg_d     = w_tx_byte;
      txp_d       = ~w_tx_byte[0];
      txn_d       = w_tx_byte[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      nlp_cnt_q   <= '0;
      tmr_q       <= '0;
      pend_q      <= 1'b0;
      len_q       <= '0;
      byte_q      <= '0;
      bit_q       <= 3'd0;
      phase_q     <= 1'b0;
      shreg_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      txp_q       <= 1'b0;
      txn_q       <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nlp_cnt_q   <= nlp_cnt_d;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
      len_q       <= len_d;
      byte_q      <= byte_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      shreg_q     <= shreg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      txp_q       <= txp_d;
      txn_q       <= txn_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign txp       = txp_q;
  assign txn       = txn_q;
  assign tx_active = tx_active_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_eth_tx.sv
// ---------------------------------------------------------------------------
// tb_sm_eth_tx : directed self-checking bench for sm_eth_tx
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sm_eth_tx;

  localparam int MEM_DEPTH = 16;
  localparam int AW        = 4;
  localparam int NLP_P     = 100;
  localparam int NLP_W     = 2;
  localparam int TPI       = 6;
  localparam int IPG       = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'd0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW:0]   len = '0;
  logic          start = 1'b0;
  logic [7:0]    rd_data;
  logic          busy, done, txp, txn, tx_active;

  sm_eth_tx #(
    .MEM_DEPTH     (MEM_DEPTH),
    .NLP_PERIOD    (NLP_P),
    .NLP_WIDTH     (NLP_W),
    .TPIDLE_CYCLES (TPI),
    .IPG_CYCLES    (IPG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .len       (len),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .txp       (txp),
    .txn       (txn),
    .tx_active (tx_active)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mdl [MEM_DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    rd_addr = a;
    tick();
    wr_en = 1'b0;
    chk("rd_back", rd_data, d);
    mdl[a] = d;
  endtask

  // mode: 0 plain, 1 write 0xFF@0 mid-DATA, 2 write 0xFF@0 in IPG, 3 extra starts while busy
  task automatic run_frame(input int nb, input int mode);
    int         dn = 0;
    logic [7:0] by;
    logic       b, ep;
    for (int i = 0; i < 16*nb; i++) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      by = mdl[i/16];
      b  = by[(i%16)/2];
      ep = (i%2 == 0) ? ~b : b;
      chk("data_line", {txp, txn, tx_active, busy}, {ep, ~ep, 1'b1, 1'b1});
      dn += int'(done);
      if (mode == 1 && i == 5) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'hFF;
      end
      if (mode == 3 && i == 3) begin
        start = 1'b1; len = 5'd2;
      end
    end
    for (int j = 0; j < TPI; j++) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      chk("tpidle_line", {txp, txn, tx_active, busy, done}, 5'b10110);
    end
    for (int j = 0; j < IPG; j++) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      chk("ipg_line", {txp, txn, tx_active, busy}, 4'b0001);
      chk("ipg_done", done, (j == 0) ? 1 : 0);
      dn += int'(done);
      if (mode == 2 && j == 3) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'hFF;
      end
      if (mode == 3 && j == 2) begin
        start = 1'b1; len = 5'd1;
      end
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("busy_fall", {busy, done}, 2'b00);
    chk("done_count", dn, 1);
  endtask

  initial begin
    logic txn_any, busy_any, done_any;
    int   wcnt;

    // 1: reset state and idle link pulses
    tick();
    chk("reset_outs", {txp, txn, busy, done, tx_active}, 5'b00000);
    rst = 1'b0;
    txn_any  = 1'b0;
    busy_any = 1'b0;
    for (int t = 1; t <= 250; t++) begin
      tick();
      chk("nlp_txp", txp, (t == 100 || t == 101 || t == 202 || t == 203) ? 1 : 0);
      txn_any  |= txn;
      busy_any |= busy | tx_active;
    end
    chk("nlp_txn_low", txn_any, 0);
    chk("nlp_busy_low", busy_any, 0);

    // 2: single byte 0x55 -> txp 0,1,1,0 x4
    wr(4'd0, 8'h55);
    len = 5'd1; start = 1'b1;
    run_frame(1, 0);

    // 3: zero length ignored, then oversize length clamped to 16 bytes
    len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_busy", busy, 0);
    tick(); tick();
    chk("len0_quiet", {busy, done, tx_active}, 3'b000);
    for (int i = 1; i < MEM_DEPTH; i++) wr(AW'(i), 8'(i*29 + 3));
    len = 5'd20; start = 1'b1;
    run_frame(16, 0);

    // 5: buffer writes dropped during DATA, accepted during IPG
    len = 5'd1; start = 1'b1;
    run_frame(1, 1);
    rd_addr = '0; #1;
    chk("rd_after_data_wr", rd_data, 8'h55);
    len = 5'd1; start = 1'b1;
    run_frame(1, 2);
    rd_addr = '0; #1;
    chk("rd_after_ipg_wr", rd_data, 8'hFF);
    mdl[0] = 8'hFF;

    // 4: NLP timer restarts after IPG; start inside NLP is deferred
    wcnt = 0;
    while (txp !== 1'b1 && wcnt < 200) begin
      tick();
      wcnt++;
    end
    chk("nlp_after_ipg", wcnt, 100);
    len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nlp_pending", {txp, txn, busy, tx_active}, 4'b1010);
    run_frame(1, 3);

    // 6: asynchronous reset mid-frame
    len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {txp, txn, busy, tx_active, done}, 5'b00000);
    tick();
    rst = 1'b0;
    done_any = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      done_any |= done | busy;
      if (t == 99)  chk("rst_nlp_early", txp, 0);
      if (t == 100) chk("rst_nlp_edge", txp, 1);
    end
    chk("rst_no_done", done_any, 0);
    rd_addr = '0; #1;
    chk("mem_kept", rd_data, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
